// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Purpose: Shared encodings for the fetch/data memory port arbiter: access
//          size codes, arbiter slot states, owner encoding and the default
//          memory window.
// Ports  : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Memory access_size encodings
   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   // Default memory window and starvation limit
   localparam logic [31:0] DEFAULT_MEM_BASE   = 32'h8002_0000;
   localparam logic [31:0] DEFAULT_MEM_SIZE   = 32'h0010_0000;
   localparam int unsigned DEFAULT_STARVE_MAX = 4;

   // State of the single in-flight memory slot
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_I = 2'd1,
      ST_GNT_D = 2'd2
   } arb_state_e;

   // Which requester owns the slot
   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   // Number of bytes touched by an access of the given size.
   // The illegal code is sized as a word; it is rejected separately.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: size_bytes = 3'd1;
         SIZE_HALF: size_bytes = 3'd2;
         default:   size_bytes = 3'd4;
      endcase
   endfunction

   function automatic owner_e state_owner(input arb_state_e st);
      state_owner = (st == ST_GNT_D) ? OWNER_D : OWNER_I;
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// ============================================================================
// Module : mem_addr_check
// Purpose: Combinational legality check for one memory request: flags
//          accesses below the window, running past its end, misaligned
//          half/word accesses and the illegal size code.
// Ports  : addr  in  32  byte address of the request
//          size  in  2   access size code
//          err   out 1   request must not reach memory
// Revision: 1.0 - initial release
// ============================================================================
module mem_addr_check
   import mem_arb_pkg::*;
#(
   parameter logic [31:0] MEM_BASE = DEFAULT_MEM_BASE,
   parameter logic [31:0] MEM_SIZE = DEFAULT_MEM_SIZE
) (
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   output logic        err
);

   // End-of-access and window limit are formed at 33 bits so an access
   // near 32'hFFFF_FFFF cannot wrap back into the window.
   localparam logic [32:0] LIMIT = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

   logic [32:0] w_end;
   logic        w_below;
   logic        w_above;
   logic        w_misalign;
   logic        w_bad_size;

   always_comb begin
      w_end      = {1'b0, addr} + {30'd0, size_bytes(size)};
      w_below    = (addr < MEM_BASE);
      w_above    = (w_end > LIMIT);
      w_misalign = ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) ||
                   ((size == SIZE_HALF) && addr[0]);
      w_bad_size = (size == SIZE_ILLEGAL);
      err        = w_below || w_above || w_misalign || w_bad_size;
   end

endmodule : mem_addr_check
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Purpose: Shares the single negedge-operated main memory port between the
//          instruction-fetch and load/store stages. One grant per cycle,
//          data has priority with a starvation bound for fetch, illegal
//          requests are answered with an error and never reach memory.
// Ports  : clk, rst_n                      clock, async active-low reset
//          i_valid/i_ready/i_addr          fetch request (32-bit reads)
//          i_rsp_valid/i_rsp_data/i_rsp_err fetch response
//          d_valid/d_ready/d_addr/d_wdata/d_write/d_size  data request
//          d_rsp_valid/d_rsp_rdata/d_rsp_err data response
//          mem_addr/mem_data_in/mem_write/mem_access_size/mem_data_out
//                                          memory port
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter logic [31:0] MEM_BASE   = DEFAULT_MEM_BASE,
   parameter logic [31:0] MEM_SIZE   = DEFAULT_MEM_SIZE,
   parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX
) (
   input  logic        clk,
   input  logic        rst_n,
   // fetch request / response
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic        i_rsp_valid,
   output logic [31:0] i_rsp_data,
   output logic        i_rsp_err,
   // data request / response
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_write,
   input  logic [1:0]  d_size,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_rdata,
   output logic        d_rsp_err,
   // memory port
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_write,
   output logic [1:0]  mem_access_size,
   input  logic [31:0] mem_data_out
);

   localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   arb_state_e       state_q,         state_d;
   logic             err_q,           err_d;
   logic             slot_wr_q,       slot_wr_d;
   logic [CNT_W-1:0] starve_cnt_q,    starve_cnt_d;
   logic [31:0]      mem_addr_q,      mem_addr_d;
   logic [31:0]      mem_data_in_q,   mem_data_in_d;
   logic             mem_write_q,     mem_write_d;
   logic [1:0]       mem_size_q,      mem_size_d;
   logic             i_rsp_valid_q,   i_rsp_valid_d;
   logic [31:0]      i_rsp_data_q,    i_rsp_data_d;
   logic             i_rsp_err_q,     i_rsp_err_d;
   logic             d_rsp_valid_q,   d_rsp_valid_d;
   logic [31:0]      d_rsp_rdata_q,   d_rsp_rdata_d;
   logic             d_rsp_err_q,     d_rsp_err_d;

   logic w_i_err;
   logic w_d_err;
   logic w_starved;
   logic w_i_hs;
   logic w_d_hs;

   // ---------------------------------------------------------------------
   // Request legality, one checker per port
   // ---------------------------------------------------------------------
   mem_addr_check #(
      .MEM_BASE (MEM_BASE),
      .MEM_SIZE (MEM_SIZE)
   ) u_i_check (
      .addr (i_addr),
      .size (SIZE_WORD),
      .err  (w_i_err)
   );

   mem_addr_check #(
      .MEM_BASE (MEM_BASE),
      .MEM_SIZE (MEM_SIZE)
   ) u_d_check (
      .addr (d_addr),
      .size (d_size),
      .err  (w_d_err)
   );

   // ---------------------------------------------------------------------
   // Grant: data wins unless fetch has waited STARVE_MAX data grants.
   // Ready already implies valid, so ready alone marks the handshake.
   // ---------------------------------------------------------------------
   always_comb begin
      w_starved = i_valid && (starve_cnt_q == CNT_MAX);
      d_ready   = d_valid && !w_starved;
      i_ready   = i_valid && !d_ready;
      w_d_hs    = d_ready;
      w_i_hs    = i_ready;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // starvation counter: only counts while fetch is actually waiting
      starve_cnt_d = starve_cnt_q;
      if (!i_valid || w_i_hs) begin
         starve_cnt_d = '0;
      end else if (w_d_hs && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end

      // slot FSM: every cycle is either a fresh grant or idle
      state_d   = ST_IDLE;
      err_d     = 1'b0;
      slot_wr_d = 1'b0;
      if (w_d_hs) begin
         state_d   = ST_GNT_D;
         err_d     = w_d_err;
         slot_wr_d = d_write;
      end else if (w_i_hs) begin
         state_d   = ST_GNT_I;
         err_d     = w_i_err;
      end

      // memory port: address/size hold on idle and on errored slots so an
      // illegal address is never presented to the memory; the read the
      // memory performs anyway is discarded by the response logic.
      mem_addr_d    = mem_addr_q;
      mem_size_d    = mem_size_q;
      mem_data_in_d = mem_data_in_q;
      mem_write_d   = 1'b0;
      if (w_d_hs) begin
         mem_data_in_d = d_wdata;
         if (!w_d_err) begin
            mem_addr_d  = d_addr;
            mem_size_d  = d_size;
            mem_write_d = d_write;
         end
      end else if (w_i_hs) begin
         mem_data_in_d = d_wdata;
         if (!w_i_err) begin
            mem_addr_d = i_addr;
            mem_size_d = SIZE_WORD;
         end
      end

      // responses: captured at the edge that ends the granted cycle,
      // mem_data_out having been produced on the negedge in between
      i_rsp_valid_d = 1'b0;
      i_rsp_data_d  = i_rsp_data_q;
      i_rsp_err_d   = i_rsp_err_q;
      d_rsp_valid_d = 1'b0;
      d_rsp_rdata_d = d_rsp_rdata_q;
      d_rsp_err_d   = d_rsp_err_q;
      if (state_q != ST_IDLE) begin
         if (state_owner(state_q) == OWNER_I) begin
            i_rsp_valid_d = 1'b1;
            i_rsp_err_d   = err_q;
            i_rsp_data_d  = err_q ? 32'd0 : mem_data_out;
         end else begin
            d_rsp_valid_d = 1'b1;
            d_rsp_err_d   = err_q;
            d_rsp_rdata_d = (err_q || slot_wr_q) ? 32'd0 : mem_data_out;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registers. Reset is asynchronous so mem_write drops immediately and a
   // pending write never reaches the following negedge.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         err_q         <= 1'b0;
         slot_wr_q     <= 1'b0;
         starve_cnt_q  <= '0;
         mem_addr_q    <= MEM_BASE;
         mem_data_in_q <= 32'd0;
         mem_write_q   <= 1'b0;
         mem_size_q    <= SIZE_WORD;
         i_rsp_valid_q <= 1'b0;
         i_rsp_data_q  <= 32'd0;
         i_rsp_err_q   <= 1'b0;
         d_rsp_valid_q <= 1'b0;
         d_rsp_rdata_q <= 32'd0;
         d_rsp_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         err_q         <= err_d;
         slot_wr_q     <= slot_wr_d;
         starve_cnt_q  <= starve_cnt_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         mem_write_q   <= mem_write_d;
         mem_size_q    <= mem_size_d;
         i_rsp_valid_q <= i_rsp_valid_d;
         i_rsp_data_q  <= i_rsp_data_d;
         i_rsp_err_q   <= i_rsp_err_d;
         d_rsp_valid_q <= d_rsp_valid_d;
         d_rsp_rdata_q <= d_rsp_rdata_d;
         d_rsp_err_q   <= d_rsp_err_d;
      end
   end

   assign mem_addr        = mem_addr_q;
   assign mem_data_in     = mem_data_in_q;
   assign mem_write       = mem_write_q;
   assign mem_access_size = mem_size_q;
   assign i_rsp_valid     = i_rsp_valid_q;
   assign i_rsp_data      = i_rsp_data_q;
   assign i_rsp_err       = i_rsp_err_q;
   assign d_rsp_valid     = d_rsp_valid_q;
   assign d_rsp_rdata     = d_rsp_rdata_q;
   assign d_rsp_err       = d_rsp_err_q;

endmodule : mem_port_arbiter
`default_nettype wire
